// File: rtl/rv_pkg.sv
// Shared types for the instruction fetch queue: FSM state encoding and queue entry layout.
package rv_pkg;

  typedef enum logic [1:0] {
    FQ_IDLE    = 2'd0,
    FQ_WAIT    = 2'd1,
    FQ_DISCARD = 2'd2
  } fetch_q_state_t;

  typedef struct packed {
    logic [31:2] pc;
    logic [31:0] instr;
  } fetch_q_entry_t;

endpackage

// File: rtl/rv_fetch_fifo.sv
// Circular buffer of fetched instructions; registered head, push/pop/flush, occupancy count.
// Latency: a push is visible at the head one cycle later; flush empties the buffer at the next edge.
module rv_fetch_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_push,
  input  fetch_q_entry_t             i_push_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output fetch_q_entry_t             o_head,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  fetch_q_entry_t  r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_pop;
  logic            w_push;

  assign w_pop  = i_pop && (r_count != '0);
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign w_push = i_push && ((r_count != CNT_FULL) || w_pop);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset_n && !i_flush && w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/rv_fetch_queue.sv
// Single-outstanding instruction fetcher feeding a DEPTH-entry queue toward decode; flush kills queued and in-flight words.
// Optional same-cycle bypass of an acked word into an empty queue: define RV_FETCH_QUEUE_BYPASS_EN.
module rv_fetch_queue
  import rv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:2] i_pc,
  input  logic        i_flush,
  output logic        o_pc_adv,
  output logic        o_bus_req,
  output logic [31:0] o_bus_addr,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:2] o_instr_pc,
  input  logic        i_instr_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  fetch_q_state_t r_state;
  fetch_q_state_t w_state_nxt;
  logic [31:2]    r_addr;
  logic           w_issue;
  logic           w_ack_ok;
  logic           w_fetch_ok;
  logic           w_q_valid;
  logic           w_push;
  logic           w_pop;
  logic [CW-1:0]  w_count;
  fetch_q_entry_t w_head;
  fetch_q_entry_t w_push_data;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= FQ_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (w_issue) r_addr <= i_pc;
  end

  // Issue only when the queue has room for the word, since nothing else is in flight from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_ack_ok    = 1'b0;
    case (r_state)
      FQ_IDLE: begin
        if (!i_flush && (w_count < CNT_FULL)) begin
          w_issue     = 1'b1;
          w_state_nxt = FQ_WAIT;
        end
      end
      FQ_WAIT: begin
        if (i_bus_ack) begin
          w_ack_ok    = !i_flush;
          w_state_nxt = FQ_IDLE;
        end else if (i_flush) begin
          w_state_nxt = FQ_DISCARD;
        end
      end
      FQ_DISCARD: begin
        if (i_bus_ack) w_state_nxt = FQ_IDLE;
      end
      default: w_state_nxt = FQ_IDLE;
    endcase
  end

  assign w_fetch_ok  = w_ack_ok && i_reset_n;
  assign w_q_valid   = (w_count != '0);
  assign w_pop       = w_q_valid && i_instr_ready;
  assign w_push_data = '{pc: r_addr, instr: i_bus_rdata};

  assign o_pc_adv   = w_fetch_ok;
  assign o_bus_req  = (r_state != FQ_IDLE);
  assign o_bus_addr = {r_addr, 2'b00};

`ifdef RV_FETCH_QUEUE_BYPASS_EN
  logic w_bypass;
  assign w_bypass      = w_fetch_ok && !w_q_valid;
  assign o_instr_valid = w_q_valid || w_bypass;
  assign o_instr       = w_q_valid ? w_head.instr : i_bus_rdata;
  assign o_instr_pc    = w_q_valid ? w_head.pc    : r_addr;
  // A bypassed word that decode takes immediately never occupies a slot.
  assign w_push        = w_fetch_ok && !(w_bypass && i_instr_ready);
`else
  assign o_instr_valid = w_q_valid;
  assign o_instr       = w_head.instr;
  assign o_instr_pc    = w_head.pc;
  assign w_push        = w_fetch_ok;
`endif

  rv_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (i_flush),
    .o_head      (w_head),
    .o_count     (w_count)
  );

endmodule

// File: doc/rv_fetch_queue.md
RV_FETCH_QUEUE -- requirements
Module: rv_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, giving the queue entry count (power of two, at least 2).
REQ-002 SHALL have i_clk  in  1  clock; all state changes on the rising edge.
REQ-003 SHALL have i_reset_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have i_pc  in  [31:2]  word address of the next fetch, driven by the PC stage.
REQ-005 SHALL have i_flush  in  1  redirect; kills queued and in-flight fetches.
REQ-006 SHALL have o_pc_adv  out  1  one-cycle pulse telling the PC stage to advance.
REQ-007 SHALL have o_bus_req  out  1  instruction bus request.
REQ-008 SHALL have o_bus_addr  out  [31:0]  request address, equal to {i_pc latched, 2'b00}.
REQ-009 SHALL have i_bus_ack  in  1  read data valid, which ends the request.
REQ-010 SHALL have i_bus_rdata  in  [31:0]  instruction word.
REQ-011 SHALL have o_instr_valid / o_instr[31:0] / o_instr_pc[31:2]  out  decode-side head entry.
REQ-012 SHALL have i_instr_ready  in  1  decode consumes the head entry when valid and ready are both high.

Function
REQ-013 SHALL use a 3-state FSM: IDLE, WAIT, DISCARD.
REQ-014 IDLE->WAIT SHALL occur when i_flush=0 and (count + 0 in flight) < DEPTH; the same edge latches i_pc into the address register.
REQ-015 o_bus_req SHALL be 1 exactly while in WAIT or DISCARD; o_bus_addr SHALL be stable for the whole request.
REQ-016 WAIT with i_bus_ack=1 and i_flush=0 SHALL push {addr, rdata} into the queue, pulse o_pc_adv in that same cycle, and go to IDLE.
REQ-017 WAIT with i_flush=1 and i_bus_ack=0 SHALL go to DISCARD.
REQ-018 WAIT with i_flush=1 and i_bus_ack=1 SHALL drop the data and go to IDLE; o_pc_adv SHALL be 0.
REQ-019 DISCARD SHALL hold o_bus_req until i_bus_ack, drop the data, and go to IDLE; o_pc_adv SHALL be 0.
REQ-020 The block SHALL allow at most one outstanding request; back-to-back fetches SHALL have a minimum of one IDLE cycle between them.
REQ-021 i_flush SHALL clear the queue (count=0) at the next edge, override a same-cycle push or pop, and block issue from IDLE in that cycle.
REQ-022 Pop and push in the same cycle SHALL leave count unchanged; this SHALL be legal when full.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; count SHALL be $clog2(DEPTH)+1 bits wide.
REQ-024 o_instr_valid SHALL equal (count != 0); o_instr and o_instr_pc SHALL show the head entry.
REQ-025 Latency from ack to o_instr_valid SHALL be 1 cycle (registered queue).

Reset
REQ-026 Reset SHALL force the FSM to IDLE, count and both pointers to 0, and o_bus_req, o_pc_adv and o_instr_valid to 0; queue data SHALL not be reset.
REQ-027 Reset during WAIT or DISCARD SHALL abandon the request; the first IDLE cycle after reset SHALL be able to issue.

Configuration
REQ-028 With RV_FETCH_QUEUE_BYPASS_EN defined and the queue empty, an ack in WAIT SHALL drive o_instr_valid/o_instr/o_instr_pc combinationally in the ack cycle.
REQ-029 Under RV_FETCH_QUEUE_BYPASS_EN, a bypassed word consumed that cycle (i_instr_ready=1) SHALL not be pushed; a word not consumed that cycle SHALL be pushed.
REQ-030 Without RV_FETCH_QUEUE_BYPASS_EN, the REQ-025 latency SHALL apply and there SHALL be no combinational path from i_bus_* to o_instr_*.

Structure
REQ-031 rv_pkg SHALL hold the FSM enum fetch_q_state_t and the struct fetch_q_entry_t {pc[31:2], instr[31:0]}.
REQ-032 Storage SHALL be a sub-module rv_fetch_fifo (parameter DEPTH; push/pop/flush; count output); the FSM stays in rv_fetch_queue.

Verification
REQ-033 Reset, i_pc=0x40: req high next cycle with addr 0x0000_0100; ack with rdata 0x00000013 -> o_pc_adv pulse in the ack cycle; next cycle valid=1, instr=0x00000013, pc=0x40.
REQ-034 Ready=0, DEPTH=2, two fetches acked -> count=2, o_bus_req stays 0; ready=1 for one cycle -> one pop, a new request is issued.
REQ-035 Flush asserted in WAIT with ack 3 cycles later -> DISCARD, no push, no o_pc_adv, valid=0, req reissued with the new i_pc.
REQ-036 Flush and ack in the same cycle -> data dropped, queue empty, IDLE next cycle.
REQ-037 Full queue, ready=1 and an ack in the same cycle -> count stays 2, order preserved, pointers wrap correctly.
REQ-038 With RV_FETCH_QUEUE_BYPASS_EN: empty queue, ack with ready=1 -> valid in the ack cycle, count stays 0.
